// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sharing one W-bit register (true/complement outputs) among NREQ requesters.
// Optional even-parity output q_par is enabled by defining REG_ARB_PARITY_EN.
module reg_share_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned W    = 8,
   parameter int unsigned CNTW = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ*W-1:0]   wdata,
   output logic [NREQ-1:0]     grant,
   output logic [NREQ-1:0]     ack,
   output logic                busy,
   output logic [W-1:0]        q,
   output logic [W-1:0]        q_c,
   output logic [CNTW-1:0]     wr_cnt
`ifdef REG_ARB_PARITY_EN
   ,
   output logic                q_par
`endif
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

   state_t          state;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   win_idx;
   logic [PW-1:0]   next_idx;
   logic            found;
   logic [W-1:0]    sel_data;

   // Scan ptr+1, ptr+2, ... (mod NREQ); the first active request wins.
   always_comb begin
      int unsigned cand;
      logic [PW-1:0] cand_idx;
      found    = 1'b0;
      next_idx = '0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         cand = 32'(ptr) + i;
         if (cand >= NREQ) cand = cand - NREQ;
         cand_idx = PW'(cand);
         if (!found && req[cand_idx]) begin
            found    = 1'b1;
            next_idx = cand_idx;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (win_idx == PW'(i)) sel_data = wdata[i*W +: W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         q       <= '0;
         grant   <= '0;
         ack     <= '0;
         wr_cnt  <= '0;
         ptr     <= PW'(NREQ - 1);
         win_idx <= '0;
`ifdef REG_ARB_PARITY_EN
         q_par   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               ack <= '0;
               if (found) begin
                  grant           <= '0;
                  grant[next_idx] <= 1'b1;
                  win_idx         <= next_idx;
                  state           <= GRANT;
               end
            end
            GRANT: begin
               q      <= sel_data;
`ifdef REG_ARB_PARITY_EN
               q_par  <= ^sel_data;
`endif
               ack    <= grant;
               grant  <= '0;
               ptr    <= win_idx;
               wr_cnt <= wr_cnt + CNTW'(1);
               state  <= ACK;
            end
            ACK: begin
               ack   <= '0;
               state <= IDLE;
            end
            default: begin
               grant <= '0;
               ack   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign q_c  = ~q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench for reg_share_arbiter: stimulus pushes expected grants/writes, a monitor pops and compares.
// Parity checks are included when REG_ARB_PARITY_EN is defined.
module tb_reg_share_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 8;
   localparam int CNTW = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [NREQ-1:0]  req;
   logic [NREQ*W-1:0] wdata;
   logic [NREQ-1:0]  grant;
   logic [NREQ-1:0]  ack;
   logic             busy;
   logic [W-1:0]     q;
   logic [W-1:0]     q_c;
   logic [CNTW-1:0]  wr_cnt;
`ifdef REG_ARB_PARITY_EN
   logic             q_par;
`endif

   reg_share_arbiter #(.NREQ(NREQ), .W(W), .CNTW(CNTW)) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .wdata  (wdata),
      .grant  (grant),
      .ack    (ack),
      .busy   (busy),
      .q      (q),
      .q_c    (q_c),
      .wr_cnt (wr_cnt)
`ifdef REG_ARB_PARITY_EN
      ,
      .q_par  (q_par)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] ack;
      logic [7:0] q;
      logic [7:0] cnt;
      logic       par;
   } exp_t;

   exp_t        aq[$];
   logic [3:0]  gq[$];
   int          compared = 0;
   int          mismatched = 0;
   int          pend[4];
   logic [3:0]  early_drop;
   logic [3:0]  ack_prev;
   logic [3:0]  grant_prev;
   logic [7:0]  exp_cnt;
   logic        spacing_chk;
   int          cyc;
   int          last_ack_cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_write(input int idx, input logic [7:0] d);
      exp_t e;
      logic [3:0] oh;
      oh = 4'(1 << idx);
      exp_cnt = exp_cnt + 8'd1;
      gq.push_back(oh);
      e.ack = oh;
      e.q   = d;
      e.cnt = exp_cnt;
      e.par = ^d;
      aq.push_back(e);
   endtask

   task automatic wait_done(input int budget);
      bit done;
      done = 1'b0;
      for (int n = 0; n < budget && !done; n++) begin
         @(negedge clk);
         if (pend[0] == 0 && pend[1] == 0 && pend[2] == 0 && pend[3] == 0 &&
             req == 4'b0 && !busy && aq.size() == 0 && gq.size() == 0)
            done = 1'b1;
      end
      if (!done) check("wait_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      exp_cnt = 8'd0;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      wdata = '0;
      for (int i = 0; i < 4; i++) pend[i] = 0;
      early_drop = '0;
      ack_prev = '0;
      grant_prev = '0;
      exp_cnt = '0;
      spacing_chk = 1'b0;
      cyc = 0;
      last_ack_cyc = -1;

      fork
         // monitor
         forever begin
            exp_t e;
            logic [7:0] nq;
            logic inv_ok;
            @(negedge clk);
            cyc++;
            if (rst) begin
               grant_prev = '0;
            end else begin
               inv_ok = (q_c == ~q) && !((|grant) && (|ack)) && $onehot0(grant) && $onehot0(ack);
               check("invariants", {31'd0, inv_ok}, 32'd1);
               if (grant != 4'b0) begin
                  if (gq.size() == 0) check("unexpected_grant", {28'd0, grant}, 32'd0);
                  else check("grant", {28'd0, grant}, {28'd0, gq.pop_front()});
               end
               if (ack != 4'b0) begin
                  check("ack_after_grant", {28'd0, ack}, {28'd0, grant_prev});
                  if (aq.size() == 0) begin
                     check("unexpected_ack", {28'd0, ack}, 32'd0);
                  end else begin
                     e = aq.pop_front();
                     nq = ~e.q;
                     check("ack", {28'd0, ack}, {28'd0, e.ack});
                     check("q", {24'd0, q}, {24'd0, e.q});
                     check("q_c", {24'd0, q_c}, {24'd0, nq});
                     check("wr_cnt", {24'd0, wr_cnt}, {24'd0, e.cnt});
`ifdef REG_ARB_PARITY_EN
                     check("q_par", {31'd0, q_par}, {31'd0, e.par});
`endif
                  end
                  if (spacing_chk && last_ack_cyc >= 0) check("ack_spacing", cyc - last_ack_cyc, 32'd3);
                  last_ack_cyc = cyc;
               end
               grant_prev = grant;
            end
         end

         // requester model: hold req until ack, drop for the following cycle
         forever begin
            @(posedge clk);
            #1;
            if (rst) begin
               req = '0;
               ack_prev = '0;
            end else begin
               for (int i = 0; i < 4; i++) begin
                  if (early_drop[i] && grant[i]) begin
                     req[i] = 1'b0;
                     pend[i] = 0;
                  end else if (ack_prev[i]) req[i] = 1'b0;
                  else if (pend[i] != 0) req[i] = 1'b1;
                  if (ack[i] && pend[i] != 0) pend[i]--;
               end
               ack_prev = ack;
            end
         end

         // stimulus
         begin
            bit seen;
            logic [7:0] d;
            repeat (2) @(negedge clk);
            check("rst_grant", {28'd0, grant}, 32'h0);
            check("rst_ack", {28'd0, ack}, 32'h0);
            check("rst_busy", {31'd0, busy}, 32'h0);
            check("rst_q", {24'd0, q}, 32'h00);
            check("rst_q_c", {24'd0, q_c}, 32'hFF);
            check("rst_wr_cnt", {24'd0, wr_cnt}, 32'h0);
            rst = 1'b0;

            // single write from requester 2
            wdata[23:16] = 8'hA5;
            expect_write(2, 8'hA5);
            pend[2] = 1;
            wait_done(30);

            // reset in the middle of GRANT
            wdata[15:8] = 8'h3C;
            gq.push_back(4'b0010);
            pend[1] = 1;
            seen = 1'b0;
            for (int n = 0; n < 10 && !seen; n++) begin
               @(negedge clk);
               if (grant == 4'b0010) seen = 1'b1;
            end
            check("midgrant_seen", {31'd0, seen}, 32'd1);
            #2 rst = 1'b1;
            pend[1] = 0;
            exp_cnt = 8'd0;
            #1;
            check("midrst_grant", {28'd0, grant}, 32'h0);
            check("midrst_ack", {28'd0, ack}, 32'h0);
            check("midrst_busy", {31'd0, busy}, 32'h0);
            check("midrst_q", {24'd0, q}, 32'h00);
            check("midrst_q_c", {24'd0, q_c}, 32'hFF);
            check("midrst_wr_cnt", {24'd0, wr_cnt}, 32'h0);
            repeat (2) @(negedge clk);
            rst = 1'b0;
            repeat (6) @(negedge clk);
            gq.delete();

            // round-robin: all four requesting
            wdata = {8'h44, 8'h33, 8'h22, 8'h11};
            spacing_chk = 1'b1;
            last_ack_cyc = -1;
            expect_write(0, 8'h11);
            expect_write(1, 8'h22);
            expect_write(2, 8'h33);
            expect_write(3, 8'h44);
            expect_write(0, 8'h11);
            pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
            wait_done(60);
            spacing_chk = 1'b0;
            check("rr_wr_cnt", {24'd0, wr_cnt}, 32'd5);

            // pointer skip: serve 1, then 0 and 1 together -> 0 first
            wdata[15:8] = 8'h5A;
            expect_write(1, 8'h5A);
            pend[1] = 1;
            wait_done(30);
            wdata[7:0]  = 8'h0F;
            wdata[15:8] = 8'hF0;
            expect_write(0, 8'h0F);
            expect_write(1, 8'hF0);
            pend[0] = 1; pend[1] = 1;
            wait_done(40);

            // requester 3 drops req during GRANT
            wdata[31:24] = 8'hC3;
            early_drop[3] = 1'b1;
            expect_write(3, 8'hC3);
            pend[3] = 1;
            wait_done(30);
            early_drop = '0;
            check("late_drop_q", {24'd0, q}, 32'hC3);

            // 256 writes from reset: counter wraps, last data 8'h07
            do_reset();
            for (int k = 0; k < 256; k++) begin
               d = 8'(k) ^ 8'hF8;
               wdata[23:16] = d;
               expect_write(2, d);
               pend[2] = 1;
               wait_done(20);
            end
            check("wrap_wr_cnt", {24'd0, wr_cnt}, 32'd0);
            check("wrap_last_q", {24'd0, q}, 32'h07);
`ifdef REG_ARB_PARITY_EN
            check("wrap_q_par", {31'd0, q_par}, 32'd1);
`endif

            check("leftover_expectations", aq.size() + gq.size(), 32'd0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
            $finish;
         end
      join
   end

endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
Round-robin arbiter that shares one W-bit register, a bank of D flip-flops with true and complement outputs, between NREQ requesters. Each requester raises a request with its write data. The arbiter grants one requester at a time, loads that requester's data into the shared register and returns a one-cycle acknowledge. It sits between the requesting control blocks and the shared state register. It also keeps a running count of completed writes.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 8, shared register width
CNTW, 8, width of the completed-write counter

Ports:
clk  input  1  single clock, all state updates on its rising edge
rst  input  1  asynchronous reset, active-high
req  input  NREQ  per-requester write request, held high until that requester's ack
wdata  input  NREQ*W  flattened write data; requester i occupies bits [i*W +: W]
grant  output  NREQ  one-hot grant, registered
ack  output  NREQ  one-hot, one-cycle write-done pulse, registered
busy  output  1  high in every state other than IDLE
q  output  W  shared register contents
q_c  output  W  bitwise complement of q (continuous assign)
wr_cnt  output  CNTW  number of completed writes, wraps

Behaviour:
- Reset (async, rst=1): state=IDLE, q=0, q_c=all ones, grant=0, ack=0, busy=0, wr_cnt=0, ptr=NREQ-1.
  - The reset value of ptr gives requester 0 highest priority on the first arbitration.
- FSM states: IDLE, GRANT, ACK.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise choose the first set req bit scanning ptr+1, ptr+2, ... modulo NREQ.
  - Register the winner into grant (one-hot) and go to GRANT.
- GRANT (exactly 1 cycle):
  - grant is held.
  - At the closing edge: q <= wdata slice of the granted requester, ack <= grant, grant <= 0, ptr <= winner index, wr_cnt <= wr_cnt+1 (modulo 2^CNTW). Go to ACK.
- ACK (exactly 1 cycle): ack is high for the winner only. At the closing edge: ack <= 0, go to IDLE.
- Latency: req sampled high in cycle 0 (IDLE) -> grant high in cycle 1 -> q and ack valid in cycle 2 -> IDLE again in cycle 3.
  - Maximum throughput is one write per 3 cycles.
- Requester protocol:
  - req is held until ack is seen, then dropped in the next cycle.
  - The arbiter samples req only in IDLE.
  - If req falls during GRANT, the write still completes and ack still pulses.
  - If the winner's req is still high in the IDLE after ACK, it loses to any other active requester because of ptr. If it is the only requester, it is served again.
- Fairness: any continuously asserted req is served within NREQ arbitrations.
- q and q_c change only at the GRANT->ACK edge or on reset. q_c == ~q at all times.
- grant and ack are never both non-zero. Neither has more than one bit set.
- Reset mid-operation: any state returns to IDLE at once. An in-flight write is discarded, and no ack is produced for it.
- wdata slices of non-granted requesters are ignored.

Optional Feature:
- Macro REG_ARB_PARITY_EN.
- Defined:
  - Adds output q_par (1 bit) = even parity (XOR) of the register contents.
  - q_par is registered in the same edge that loads q, so it always matches q.
  - Reset value of q_par is 0.
- Undefined: the q_par port and its logic are absent. All other behaviour is unchanged.

Test Plan:
- Reset: assert rst mid-GRANT with req=4'b0010 -> immediately grant=0, ack=0, busy=0, q=8'h00, q_c=8'hFF, wr_cnt=0; no ack afterwards.
- Single write: req=4'b0100, wdata[23:16]=8'hA5, held until ack:
  - grant=4'b0100 in cycle 1.
  - q=8'hA5, q_c=8'h5A and ack=4'b0100 in cycle 2.
  - wr_cnt=1.
- Round-robin: req=4'b1111 held continuously (each requester drops req for one cycle after its ack, then re-raises) -> grant order 0,1,2,3,0; one ack per 3 cycles; wr_cnt=5 after the fifth ack.
- Pointer skip: after serving requester 1, assert req=4'b0011 -> requester 0 is granted next, not 1.
- Late req drop: req=4'b1000, drop req during GRANT -> q still loads wdata[31:24], ack=4'b1000 pulses once.
- Counter wrap and parity (REG_ARB_PARITY_EN defined):
  - Perform 256 writes -> wr_cnt returns to 0.
  - Write 8'h07 -> q_par=1 in the same cycle q updates.
